// File: rtl/cr16_ext_mem_io.sv
// Memory-mapped I/O target on the CR16 external data port: display, LEDs,
// switches, button press flags and a prescaled timer with a compare flag.
module cr16_ext_mem_io #(
  parameter logic [15:0] P_BASE_ADDRESS = 16'hFF00,
  parameter int unsigned P_TIMER_DIVIDE = 50000
) (
  input  logic        I_CLK,
  input  logic        I_NRESET,
  input  logic        I_ENABLE,
  input  logic [15:0] I_EXT_MEM_DATA,
  input  logic [15:0] I_EXT_MEM_ADDRESS,
  input  logic        I_EXT_MEM_WRITE_ENABLE,
  output logic [15:0] O_EXT_MEM_DATA,
  input  logic [9:0]  I_SWITCHES,
  input  logic [3:0]  I_NBUTTONS,
  output logic [9:0]  O_LEDS,
  output logic [15:0] O_DISPLAY_VALUE
);

  localparam logic [3:0]  OFF_DISPLAY = 4'h0;
  localparam logic [3:0]  OFF_LEDS    = 4'h1;
  localparam logic [3:0]  OFF_SWITCH  = 4'h2;
  localparam logic [3:0]  OFF_BTN     = 4'h3;
  localparam logic [3:0]  OFF_COUNT   = 4'h4;
  localparam logic [3:0]  OFF_COMPARE = 4'h5;
  localparam logic [3:0]  OFF_STATUS  = 4'h6;
  localparam logic [15:0] DIV_LAST    = 16'(P_TIMER_DIVIDE - 1);

  logic        hit;
  logic [3:0]  offset;
  logic        wr;

  logic [15:0] display_q;
  logic [9:0]  leds_q;
  logic [9:0]  sw_s1, sw_s2;
  logic [3:0]  btn_s1, btn_s2, btn_prev;
  logic [3:0]  btn_edge_q;
  logic [3:0]  btn_fall;
  logic [3:0]  btn_w1c;
  logic [15:0] presc_q;
  logic [15:0] count_q;
  logic [15:0] count_next;
  logic [15:0] compare_q;
  logic        match_q;
  logic        tick;
  logic        count_clr;
  logic        match_set;
  logic        match_w1c;
  logic [15:0] rd_mux;

  assign hit    = (I_EXT_MEM_ADDRESS[15:4] == P_BASE_ADDRESS[15:4]);
  assign offset = I_EXT_MEM_ADDRESS[3:0];
  assign wr     = I_EXT_MEM_WRITE_ENABLE & hit;

  assign btn_fall   = btn_prev & ~btn_s2;
  assign btn_w1c    = (wr && offset == OFF_BTN) ? I_EXT_MEM_DATA[3:0] : '0;

  assign tick       = I_ENABLE && (presc_q == DIV_LAST);
  assign count_clr  = wr && (offset == OFF_COUNT);
  assign count_next = count_q + 16'd1;
  // A count-clear write suppresses both the increment and the compare.
  assign match_set  = tick && !count_clr && (count_next == compare_q);
  assign match_w1c  = wr && (offset == OFF_STATUS) && I_EXT_MEM_DATA[0];

  always_comb begin
    rd_mux = '0;
    if (hit) begin
      case (offset)
        OFF_DISPLAY: rd_mux = display_q;
        OFF_LEDS:    rd_mux = {6'b0, leds_q};
        OFF_SWITCH:  rd_mux = {6'b0, sw_s2};
        OFF_BTN:     rd_mux = {12'b0, btn_edge_q};
        OFF_COUNT:   rd_mux = count_q;
        OFF_COMPARE: rd_mux = compare_q;
        OFF_STATUS:  rd_mux = {15'b0, match_q};
        default:     rd_mux = '0;
      endcase
    end
  end

  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      O_EXT_MEM_DATA <= '0;
      display_q      <= '0;
      leds_q         <= '0;
      compare_q      <= '0;
    end else begin
      O_EXT_MEM_DATA <= rd_mux;
      if (wr && offset == OFF_DISPLAY) display_q <= I_EXT_MEM_DATA;
      if (wr && offset == OFF_LEDS)    leds_q    <= I_EXT_MEM_DATA[9:0];
      if (wr && offset == OFF_COMPARE) compare_q <= I_EXT_MEM_DATA;
    end
  end

  // Button flops reset to the released level so reset exit never looks like a press.
  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      sw_s1      <= '0;
      sw_s2      <= '0;
      btn_s1     <= '1;
      btn_s2     <= '1;
      btn_prev   <= '1;
      btn_edge_q <= '0;
    end else begin
      sw_s1      <= I_SWITCHES;
      sw_s2      <= sw_s1;
      btn_s1     <= I_NBUTTONS;
      btn_s2     <= btn_s1;
      btn_prev   <= btn_s2;
      btn_edge_q <= (btn_edge_q & ~btn_w1c) | btn_fall;
    end
  end

  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      presc_q <= '0;
      count_q <= '0;
      match_q <= 1'b0;
    end else begin
      if (count_clr) begin
        presc_q <= '0;
        count_q <= '0;
      end else if (tick) begin
        presc_q <= '0;
        count_q <= count_next;
      end else if (I_ENABLE) begin
        presc_q <= presc_q + 16'd1;
      end
      match_q <= (match_q & ~match_w1c) | match_set;
    end
  end

  assign O_LEDS          = leds_q;
  assign O_DISPLAY_VALUE = display_q;

endmodule

// File: tb/tb_cr16_ext_mem_io.sv
// Directed and randomized checks of cr16_ext_mem_io against a register-level model.
module tb_cr16_ext_mem_io;

  localparam int unsigned TB_DIV = 4;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        en    = 1'b0;
  logic        en1   = 1'b0;
  logic        wen   = 1'b0;
  logic [15:0] addr  = '0;
  logic [15:0] wdata = '0;
  logic [9:0]  sw    = '0;
  logic [3:0]  nbtn  = '1;
  logic [15:0] rdata, disp, rdata1, disp1;
  logic [9:0]  leds, leds1;

  int n_assert = 0;
  int n_fail   = 0;

  // Model state for the DIVIDE=4 instance.
  logic [15:0] m_disp;
  logic [9:0]  m_leds;
  logic [15:0] m_cmp;
  int unsigned m_en_edges;
  logic        m_flag;
  logic [15:0] exp_rd;

  cr16_ext_mem_io #(.P_BASE_ADDRESS(16'hFF00), .P_TIMER_DIVIDE(TB_DIV)) dut (
    .I_CLK(clk), .I_NRESET(rst_n), .I_ENABLE(en),
    .I_EXT_MEM_DATA(wdata), .I_EXT_MEM_ADDRESS(addr),
    .I_EXT_MEM_WRITE_ENABLE(wen), .O_EXT_MEM_DATA(rdata),
    .I_SWITCHES(sw), .I_NBUTTONS(nbtn), .O_LEDS(leds), .O_DISPLAY_VALUE(disp)
  );

  cr16_ext_mem_io #(.P_BASE_ADDRESS(16'hFF00), .P_TIMER_DIVIDE(1)) dut1 (
    .I_CLK(clk), .I_NRESET(rst_n), .I_ENABLE(en1),
    .I_EXT_MEM_DATA(wdata), .I_EXT_MEM_ADDRESS(addr),
    .I_EXT_MEM_WRITE_ENABLE(wen), .O_EXT_MEM_DATA(rdata1),
    .I_SWITCHES(sw), .I_NBUTTONS(nbtn), .O_LEDS(leds1), .O_DISPLAY_VALUE(disp1)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] m_count();
    return 16'(m_en_edges / TB_DIV);
  endfunction

  function automatic logic [15:0] model_read(input logic [15:0] a);
    if (a[15:4] != 12'hFF0) return 16'h0;
    case (a[3:0])
      4'h0:    return m_disp;
      4'h1:    return {6'b0, m_leds};
      4'h2:    return {6'b0, sw};
      4'h4:    return m_count();
      4'h5:    return m_cmp;
      4'h6:    return {15'b0, m_flag};
      default: return 16'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_disp = '0; m_leds = '0; m_cmp = '0; m_en_edges = 0; m_flag = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One bus cycle: drive, take an edge, advance the model, sample 1 time unit later.
  task automatic cyc(input logic [15:0] a, input logic [15:0] d, input logic we);
    logic        hit;
    logic [15:0] cmp_old;
    logic        set;
    addr = a; wdata = d; wen = we;
    exp_rd = model_read(a);
    hit = (a[15:4] == 12'hFF0);
    cmp_old = m_cmp;
    @(posedge clk);
    set = 1'b0;
    if (we && hit && a[3:0] == 4'h0) m_disp = d;
    if (we && hit && a[3:0] == 4'h1) m_leds = d[9:0];
    if (we && hit && a[3:0] == 4'h5) m_cmp = d;
    if (we && hit && a[3:0] == 4'h4) m_en_edges = 0;
    else if (en) begin
      m_en_edges++;
      if ((m_en_edges % TB_DIV) == 0 && m_count() == cmp_old) set = 1'b1;
    end
    if (we && hit && a[3:0] == 4'h6 && d[0]) m_flag = 1'b0;
    if (set) m_flag = 1'b1;
    #1;
    wen = 1'b0;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) cyc(16'h0000, 16'h0, 1'b0);
  endtask

  task automatic rd(input string tag, input logic [15:0] a, input logic [15:0] exp);
    cyc(a, 16'h0, 1'b0);
    chk(tag, rdata, exp);
  endtask

  task automatic rd1(input string tag, input logic [15:0] a, input logic [15:0] exp);
    cyc(a, 16'h0, 1'b0);
    chk(tag, rdata1, exp);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rdata", rdata, 16'h0);
    chk("reset_leds", {6'b0, leds}, 16'h0);
    chk("reset_disp", disp, 16'h0);
    rst_n = 1'b1;

    for (int unsigned i = 0; i < 16; i++) rd("reset_readback", 16'hFF00 | 16'(i), 16'h0);
    chk("idle_leds", {6'b0, leds}, 16'h0);
    chk("idle_disp", disp, 16'h0);

    cyc(16'hFF00, 16'hBEEF, 1'b1);
    chk("disp_out", disp, 16'hBEEF);
    rd("disp_rd", 16'hFF00, 16'hBEEF);
    cyc(16'hFF01, 16'hFFFF, 1'b1);
    chk("leds_out", {6'b0, leds}, 16'h03FF);
    rd("leds_rd", 16'hFF01, 16'h03FF);

    cyc(16'hFE00, 16'h1111, 1'b1);
    cyc(16'hFF07, 16'h2222, 1'b1);
    chk("miss_disp", disp, 16'hBEEF);
    chk("miss_leds", {6'b0, leds}, 16'h03FF);
    rd("miss_rd", 16'hFE00, 16'h0);
    rd("unused_rd", 16'hFF07, 16'h0);

    cyc(16'hFF00, 16'h1234, 1'b1);
    cyc(16'hFF00, 16'h5678, 1'b1);
    chk("rw_same_old", rdata, 16'h1234);
    rd("rw_same_new", 16'hFF00, 16'h5678);

    // Button 2 low for five cycles; flag lands on the third edge.
    nbtn[2] = 1'b0;
    idle(1);
    rd("btn_early", 16'hFF03, 16'h0);
    rd("btn_edge3", 16'hFF03, 16'h0);
    rd("btn_set", 16'hFF03, 16'h0004);
    idle(1);
    nbtn[2] = 1'b1;
    idle(3);
    rd("btn_sticky", 16'hFF03, 16'h0004);
    cyc(16'hFF03, 16'h0004, 1'b1);
    rd("btn_w1c", 16'hFF03, 16'h0);
    nbtn[2] = 1'b0;
    idle(2);
    cyc(16'hFF03, 16'h0004, 1'b1);
    rd("btn_set_wins", 16'hFF03, 16'h0004);
    nbtn[2] = 1'b1;
    idle(3);
    cyc(16'hFF03, 16'h000F, 1'b1);
    rd("btn_clear2", 16'hFF03, 16'h0);

    sw = 10'h2A5;
    idle(1);
    rd("sw_early", 16'hFF02, 16'h0);
    rd("sw_sync", 16'hFF02, 16'h02A5);

    cyc(16'hFF04, 16'h0, 1'b1);
    cyc(16'hFF05, 16'h0003, 1'b1);
    cyc(16'hFF06, 16'h0001, 1'b1);
    en = 1'b1;
    idle(12);
    rd("tmr_count12", 16'hFF04, 16'h0003);
    rd("tmr_status", 16'hFF06, 16'h0001);
    en = 1'b0;
    idle(10);
    rd("tmr_hold", 16'hFF04, 16'h0003);
    cyc(16'hFF04, 16'h0, 1'b1);
    rd("tmr_clear", 16'hFF04, 16'h0);
    en = 1'b1;
    idle(3);
    rd("tmr_presc_clr", 16'hFF04, 16'h0);
    rd("tmr_first_tick", 16'hFF04, 16'h0001);
    en = 1'b0;

    rd("pre_rst_status", 16'hFF06, 16'h0001);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_rdata", rdata, 16'h0);
    chk("midrst_leds", {6'b0, leds}, 16'h0);
    chk("midrst_disp", disp, 16'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    rd("postrst_leds", 16'hFF01, 16'h0);
    rd("postrst_status", 16'hFF06, 16'h0);
    idle(2);
    rd("postrst_btn", 16'hFF03, 16'h0);
    rd("postrst_count", 16'hFF04, 16'h0);

    for (int unsigned i = 0; i < 300; i++) begin
      logic [15:0] a;
      logic [15:0] d;
      en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) a = {4'hA, 12'($urandom)};
      else a = {12'hFF0, 4'($urandom_range(0, 15))};
      d = 16'($urandom);
      if (a[3:0] == 4'h5) d = 16'($urandom_range(0, 6));
      cyc(a, d, ($urandom_range(0, 2) == 0) && !(a[3:0] == 4'h4 && $urandom_range(0, 3) != 0));
      chk("rand_rd", rdata, exp_rd);
      chk("rand_leds", {6'b0, leds}, {6'b0, m_leds});
      chk("rand_disp", disp, m_disp);
    end
    en = 1'b0;

    // DIVIDE=1 instance: run the count up to 16'hFFFF and across the wrap.
    cyc(16'hFF05, 16'h0000, 1'b1);
    cyc(16'hFF06, 16'h0001, 1'b1);
    cyc(16'hFF04, 16'h0000, 1'b1);
    en1 = 1'b1;
    idle(65534);
    rd1("wrap_no_match", 16'hFF06, 16'h0);
    rd1("wrap_ffff", 16'hFF04, 16'hFFFF);
    rd1("wrap_zero", 16'hFF04, 16'h0);
    rd1("wrap_match", 16'hFF06, 16'h0001);
    en1 = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/cr16_ext_mem_io.md
# cr16_ext_mem_io

Memory-mapped I/O responder on the CR16 external memory bus. It is the target end of the processor's external data port: it decodes the address, performs register writes, and returns registered read data with the same one-cycle latency as the BRAM. It holds a 7-segment display value and an LED register, samples the board switches and buttons, and provides a prescaled timer with a compare flag.

## Interface
- P_BASE_ADDRESS, 16'hFF00, base of the 16-word register window; must be 16-aligned
- P_TIMER_DIVIDE, 50000, clock cycles per timer tick; range 1..65535
- I_CLK  in  1  system clock; all state changes on the rising edge
- I_NRESET  in  1  reset, asynchronous and active-low
- I_ENABLE  in  1  timer run enable; the bus and I/O registers keep working when low
- I_EXT_MEM_DATA  in  16  write data driven by the CR16
- I_EXT_MEM_ADDRESS  in  16  word address driven by the CR16
- I_EXT_MEM_WRITE_ENABLE  in  1  write strobe, one cycle per write
- O_EXT_MEM_DATA  out  16  registered read data returned to the CR16
- I_SWITCHES  in  10  asynchronous switch levels
- I_NBUTTONS  in  4  asynchronous push buttons, active-low
- O_LEDS  out  10  LED register
- O_DISPLAY_VALUE  out  16  value shown on the four 7-segment digits

## Operation
- Hit: `I_EXT_MEM_ADDRESS[15:4] == P_BASE_ADDRESS[15:4]`. The offset is address[3:0].
- Register map:
  - 0x0 DISPLAY: RW, 16 bits, drives O_DISPLAY_VALUE.
  - 0x1 LEDS: RW, bits [9:0]; read [15:10] = 0.
  - 0x2 SWITCHES: RO, synchronized switches in [9:0].
  - 0x3 BTN_EDGE: sticky press flags in [3:0]; write 1 to clear per bit.
  - 0x4 TIMER_COUNT: RO count. Any write clears both count and prescaler to 0.
  - 0x5 TIMER_COMPARE: RW, 16 bits.
  - 0x6 TIMER_STATUS: bit0 is the sticky match flag; write 1 to clear.
  - 0x7–0xF: read 0, writes ignored.
- Write: occurs on the rising edge when write enable is high and the address hits. A miss with write enable high has no effect.
- Read: on every edge, O_EXT_MEM_DATA <= hit ? reg[offset] : 16'h0. The value is the pre-edge register content, so a read and write to the same address in the same cycle return the old value.
- Synchronizers: two flops on each of I_SWITCHES and I_NBUTTONS. Each button has a third flop that holds the previous synchronized value.
- Press: a synchronized falling edge (prev = 1, now = 0) sets BTN_EDGE[i]. If a set and a W1C land on the same bit in the same cycle, the set wins.
- Prescaler: counts 0..P_TIMER_DIVIDE-1 while I_ENABLE = 1 and wraps to 0. The wrap cycle is a tick, which increments TIMER_COUNT; 16'hFFFF wraps to 0.
- Match: a tick whose new count equals TIMER_COMPARE sets TIMER_STATUS[0]. A set and a W1C in the same cycle: the set wins.
- I_ENABLE = 0 freezes the prescaler and count. Compare is only evaluated on ticks.
- A count-clear write in the same cycle as a tick: the clear wins, and no match is evaluated.

## Timing
- Reset values while I_NRESET = 0: every register, O_EXT_MEM_DATA, O_LEDS, O_DISPLAY_VALUE, prescaler and count are 0. Button sync and prev flops reset to 1 (released), so there is no false press on reset release. Switch sync flops reset to 0.
- Reset asserted mid-operation clears everything immediately (asynchronous). The first edge after release behaves as a normal cycle.
- Read latency is 1 cycle: address at edge k gives data valid after edge k, held until the next edge.
- Writes are visible on outputs (O_LEDS, O_DISPLAY_VALUE) after the writing edge. They are visible to a read presented one cycle later.
- Switch change before edge k appears in SWITCHES after edge k+1 and is readable at O_EXT_MEM_DATA after edge k+2.
- Button low before edge k: BTN_EDGE bit set after edge k+2.
- Timer with DIVIDE = D: the first tick occurs D edges after enable rises (counting from prescaler 0). D = 1 ticks every cycle.

## Test plan
- Reset/readback:
  - After reset release, read all offsets 0x0–0xF: every read is 0, O_LEDS = 0, O_DISPLAY_VALUE = 0.
  - Write 16'hBEEF to 0xFF00: O_DISPLAY_VALUE = 16'hBEEF next cycle, readback = 16'hBEEF.
  - Write 16'hFFFF to 0xFF01: readback = 16'h03FF.
- Decode miss and same-cycle access:
  - Write to 0xFE00 and to 0xFF07: no register changes, reads return 0.
  - Read and write 0xFF00 in the same cycle (old value 16'h1234, new value 16'h5678): read returns 16'h1234, and the next read returns 16'h5678.
- Buttons:
  - Pulse I_NBUTTONS[2] low for 5 cycles: BTN_EDGE = 4'b0100 after 3 edges and stays set after release.
  - Write 16'h0004: the bit clears.
  - Press coincident with the W1C edge: the bit remains 1.
- Switches: drive I_SWITCHES = 10'h2A5 asynchronously; a read of 0xFF02 issued after edge k+1 returns 16'h02A5.
- Timer with P_TIMER_DIVIDE = 4, I_ENABLE = 1, COMPARE = 3:
  - COUNT = 3 after 12 edges and TIMER_STATUS = 1.
  - Drop I_ENABLE for 10 cycles: COUNT holds.
  - Write 0x4: COUNT and prescaler return to 0.
  - Preload COUNT to 16'hFFFF via ticks: the next tick gives 0.
- Mid-operation reset: assert I_NRESET low between edges while LEDS = 16'h3FF and status = 1. All outputs read 0 immediately, with no false button edge after release.
